instruction_decode_stage: RTL and testbench

INSTRUCTION_DECODE_STAGE -- requirements
Module: instruction_decode_stage

---
 rtl/instruction_decode_stage.sv | 153 +++++++++++++++
 tb/tb_instruction_decode_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode_stage.sv
// rtl/instruction_decode_stage.sv - decode stage with main + skid entry buffering
module instruction_decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic [31:0] instr_pc,
    output logic        instr_ready,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [4:0]  operand_1,
    output logic [4:0]  operand_2,
    output logic [31:0] gpr_destination_address,
    output logic [3:0]  alu_control,
    output logic        reg_write,
    output logic [15:0] immediate_value,
    output logic [31:0] PC,
    output logic        illegal,
    output logic [7:0]  illegal_count
);

    typedef struct packed {
        logic [4:0]  op1;
        logic [4:0]  op2;
        logic [31:0] dest;
        logic [3:0]  alu;
        logic        rw;
        logic [15:0] imm;
        logic [31:0] pc;
        logic        ill;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t     state;
    entry_t     main_q;
    entry_t     skid_q;
    entry_t     dec;
    logic       instr_ready_q;
    logic       out_valid_q;
    logic [7:0] illegal_count_q;
    logic       accept;
    logic       consume;

    always_comb begin
        dec      = '0;
        dec.op1  = instr[25:21];
        dec.pc   = instr_pc;
        if (instr[31:26] == 6'b000000 && instr[5:0] == 6'b100000) begin
            dec.op2  = instr[20:16];
            dec.dest = {27'd0, instr[15:11]};
            dec.alu  = 4'b0001;
            dec.rw   = 1'b1;
        end else if (instr[31:26] == 6'b000000 && instr[5:0] == 6'b100010) begin
            dec.op2  = instr[20:16];
            dec.dest = {27'd0, instr[15:11]};
            dec.alu  = 4'b0010;
            dec.rw   = 1'b1;
        end else if (instr[31:26] == 6'b001000) begin
            dec.dest = {27'd0, instr[20:16]};
            dec.alu  = 4'b0011;
            dec.rw   = 1'b1;
            dec.imm  = instr[15:0];
        end else if (instr[31:26] == 6'b000010) begin
            dec.dest = {6'd0, instr[25:0]};
            dec.alu  = 4'b0100;
        end else begin
            dec.ill  = 1'b1;
        end
    end

    assign accept  = instr_valid && instr_ready_q;
    assign consume = out_valid_q && out_ready;

    // Main is cleared whenever the stage empties so idle outputs read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= EMPTY;
            main_q        <= '0;
            skid_q        <= '0;
            instr_ready_q <= 1'b0;
            out_valid_q   <= 1'b0;
        end else if (flush) begin
            state         <= EMPTY;
            main_q        <= '0;
            skid_q        <= '0;
            instr_ready_q <= 1'b1;
            out_valid_q   <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    instr_ready_q <= 1'b1;
                    if (accept) begin
                        main_q      <= dec;
                        state       <= ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !consume) begin
                        skid_q        <= dec;
                        state         <= FULL;
                        instr_ready_q <= 1'b0;
                    end else if (consume && !accept) begin
                        main_q      <= '0;
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end else if (consume && accept) begin
                        main_q <= dec;
                    end
                end
                FULL: begin
                    if (consume) begin
                        main_q        <= skid_q;
                        skid_q        <= '0;
                        state         <= ONE;
                        instr_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state         <= EMPTY;
                    main_q        <= '0;
                    skid_q        <= '0;
                    instr_ready_q <= 1'b1;
                    out_valid_q   <= 1'b0;
                end
            endcase
        end
    end

    // Counts consumed illegal entries even on a flushing edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_count_q <= 8'd0;
        end else if (consume && main_q.ill && illegal_count_q != 8'hFF) begin
            illegal_count_q <= illegal_count_q + 8'd1;
        end
    end

    assign instr_ready             = instr_ready_q;
    assign out_valid               = out_valid_q;
    assign operand_1               = main_q.op1;
    assign operand_2               = main_q.op2;
    assign gpr_destination_address = main_q.dest;
    assign alu_control             = main_q.alu;
    assign reg_write               = main_q.rw;
    assign immediate_value         = main_q.imm;
    assign PC                      = main_q.pc;
    assign illegal                 = main_q.ill;
    assign illegal_count           = illegal_count_q;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// tb/tb_instruction_decode_stage.sv - scoreboard bench for instruction_decode_stage
module tb_instruction_decode_stage;

    typedef struct packed {
        logic [4:0]  op1;
        logic [4:0]  op2;
        logic [31:0] dest;
        logic [3:0]  alu;
        logic        rw;
        logic [15:0] imm;
        logic [31:0] pc;
        logic        ill;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [4:0]  operand_1;
    logic [4:0]  operand_2;
    logic [31:0] gpr_destination_address;
    logic [3:0]  alu_control;
    logic        reg_write;
    logic [15:0] immediate_value;
    logic [31:0] PC;
    logic        illegal;
    logic [7:0]  illegal_count;

    entry_t q[$];
    entry_t mon_got;
    entry_t mon_exp;
    int     pass_cnt = 0;
    int     chk_cnt  = 0;

    instruction_decode_stage dut (
        .clk                     (clk),
        .rst                     (rst),
        .instr_valid             (instr_valid),
        .instr                   (instr),
        .instr_pc                (instr_pc),
        .instr_ready             (instr_ready),
        .flush                   (flush),
        .out_ready               (out_ready),
        .out_valid               (out_valid),
        .operand_1               (operand_1),
        .operand_2               (operand_2),
        .gpr_destination_address (gpr_destination_address),
        .alu_control             (alu_control),
        .reg_write               (reg_write),
        .immediate_value         (immediate_value),
        .PC                      (PC),
        .illegal                 (illegal),
        .illegal_count           (illegal_count)
    );

    always #5 clk = ~clk;

    function automatic entry_t mk(input logic [4:0] op1, input logic [4:0] op2,
                                  input logic [31:0] dest, input logic [3:0] alu,
                                  input logic rw, input logic [15:0] imm,
                                  input logic [31:0] pc, input logic ill);
        entry_t e;
        e.op1 = op1; e.op2 = op2; e.dest = dest; e.alu = alu;
        e.rw = rw; e.imm = imm; e.pc = pc; e.ill = ill;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] w, input logic [31:0] pc, input entry_t e);
        int n = 0;
        instr = w; instr_pc = pc; instr_valid = 1'b1;
        @(negedge clk);
        while (!instr_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!instr_ready) begin
            chk_cnt++;
            $display("FAIL send_timeout: got instr_ready 0 expected 1 (pc %h)", pc);
        end else begin
            q.push_back(e);
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            mon_got = mk(operand_1, operand_2, gpr_destination_address, alu_control,
                         reg_write, immediate_value, PC, illegal);
            chk_cnt++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_output: got entry %h expected none", mon_got);
            end else begin
                mon_exp = q.pop_front();
                if (mon_got === mon_exp) pass_cnt++;
                else $display("FAIL out_entry: got %h expected %h", mon_got, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = '0; instr_pc = '0;
        flush = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_instr_ready", {31'd0, instr_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_illegal_count", {24'd0, illegal_count}, 32'd0);
        check("rst_pc", PC, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", {31'd0, instr_ready}, 32'd1);

        // Directed decode vectors, streaming with out_ready high
        out_ready = 1'b1;
        send(32'h00221820, 32'h100, mk(5'd1, 5'd2, 32'd3, 4'b0001, 1'b1, 16'h0, 32'h100, 1'b0));
        check("latency_out_valid", {31'd0, out_valid}, 32'd1);
        send(32'h00221822, 32'h104, mk(5'd1, 5'd2, 32'd3, 4'b0010, 1'b1, 16'h0, 32'h104, 1'b0));
        send(32'h20221212, 32'h108, mk(5'd1, 5'd0, 32'd2, 4'b0011, 1'b1, 16'h1212, 32'h108, 1'b0));
        send(32'h08000021, 32'h10c, mk(5'd0, 5'd0, 32'h21, 4'b0100, 1'b0, 16'h0, 32'h10c, 1'b0));
        send(32'hFC000000, 32'h110, mk(5'd0, 5'd0, 32'd0, 4'b0000, 1'b0, 16'h0, 32'h110, 1'b1));
        send(32'h00221821, 32'h114, mk(5'd1, 5'd0, 32'd0, 4'b0000, 1'b0, 16'h0, 32'h114, 1'b1));
        drain(3);
        check("illegal_count_two", {24'd0, illegal_count}, 32'd2);
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
        check("idle_operand_1", {27'd0, operand_1}, 32'd0);
        check("idle_pc", PC, 32'd0);

        // Backpressure: two fill main+skid, third waits for the freeing cycle
        out_ready = 1'b0;
        send(32'h00221820, 32'h200, mk(5'd1, 5'd2, 32'd3, 4'b0001, 1'b1, 16'h0, 32'h200, 1'b0));
        send(32'h00221822, 32'h204, mk(5'd1, 5'd2, 32'd3, 4'b0010, 1'b1, 16'h0, 32'h204, 1'b0));
        check("full_instr_ready", {31'd0, instr_ready}, 32'd0);
        check("full_out_valid", {31'd0, out_valid}, 32'd1);
        drain(2);
        check("full_hold_pc", PC, 32'h200);
        fork
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            send(32'h08000021, 32'h208, mk(5'd0, 5'd0, 32'h21, 4'b0100, 1'b0, 16'h0, 32'h208, 1'b0));
        join
        drain(4);
        check("backpressure_drained", q.size(), 32'd0);

        // Saturation of the illegal counter
        for (int i = 0; i < 300; i++) begin
            send(32'hFC000000, 32'h1000 + 32'(i) * 4,
                 mk(5'd0, 5'd0, 32'd0, 4'b0000, 1'b0, 16'h0, 32'h1000 + 32'(i) * 4, 1'b1));
        end
        drain(3);
        check("illegal_count_sat", {24'd0, illegal_count}, 32'hFF);

        // Flush while FULL
        out_ready = 1'b0;
        send(32'h00221820, 32'h300, mk(5'd1, 5'd2, 32'd3, 4'b0001, 1'b1, 16'h0, 32'h300, 1'b0));
        send(32'h00221822, 32'h304, mk(5'd1, 5'd2, 32'd3, 4'b0010, 1'b1, 16'h0, 32'h304, 1'b0));
        flush = 1'b1; instr_valid = 1'b1; instr = 32'h20221212; instr_pc = 32'h308;
        @(posedge clk); #1;
        flush = 1'b0; instr_valid = 1'b0;
        q.delete();
        check("flush_full_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_full_instr_ready", {31'd0, instr_ready}, 32'd1);
        check("flush_full_pc", PC, 32'd0);
        check("flush_count_kept", {24'd0, illegal_count}, 32'hFF);
        out_ready = 1'b1;
        drain(3);

        // Flush while ONE with a presented, ready-qualified instruction
        out_ready = 1'b0;
        send(32'h00221820, 32'h400, mk(5'd1, 5'd2, 32'd3, 4'b0001, 1'b1, 16'h0, 32'h400, 1'b0));
        flush = 1'b1; instr_valid = 1'b1; instr = 32'h00221822; instr_pc = 32'h404;
        @(posedge clk); #1;
        flush = 1'b0; instr_valid = 1'b0;
        q.delete();
        check("flush_one_out_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        drain(3);

        // Asynchronous reset mid-cycle while FULL
        out_ready = 1'b0;
        send(32'h00221820, 32'h500, mk(5'd1, 5'd2, 32'd3, 4'b0001, 1'b1, 16'h0, 32'h500, 1'b0));
        send(32'h00221822, 32'h504, mk(5'd1, 5'd2, 32'd3, 4'b0010, 1'b1, 16'h0, 32'h504, 1'b0));
        #2 rst = 1'b1;
        #1;
        q.delete();
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_pc", PC, 32'd0);
        check("arst_alu", {28'd0, alu_control}, 32'd0);
        check("arst_operand_1", {27'd0, operand_1}, 32'd0);
        check("arst_instr_ready", {31'd0, instr_ready}, 32'd0);
        check("arst_illegal_count", {24'd0, illegal_count}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        check("arst_ready_before_edge", {31'd0, instr_ready}, 32'd0);
        @(posedge clk); #1;
        check("arst_ready_after_edge", {31'd0, instr_ready}, 32'd1);
        check("arst_no_emit", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        drain(3);

        check("scoreboard_empty", q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
